// File: rtl/alu_pipe_unit.sv
// Configurable-width ALU with multiply-accumulate, feeding a PIPE_DEPTH-stage
// elastic valid/ready output pipeline. Replaces the fixed ALU + reg_unit pair.
module alu_pipe_unit #(
  parameter int DATA_WIDTH   = 32,
  parameter int PIPE_DEPTH   = 2,
  parameter int ALU_FUNC     = 0,
  parameter int DYNAMIC_FUNC = 0,
  parameter int TIDE_EN      = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [2:0]            alu_func,
  input  logic [DATA_WIDTH-1:0] data_in1,
  input  logic [DATA_WIDTH-1:0] data_in2,
  input  logic [DATA_WIDTH-1:0] data_in3,
  input  logic                  acc_clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  ovf_out,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int MSB = DATA_WIDTH - 1;

  typedef enum logic [2:0] {
    FN_ADD = 3'd0,
    FN_SUB = 3'd1,
    FN_AND = 3'd2,
    FN_OR  = 3'd3,
    FN_XOR = 3'd4,
    FN_MAD = 3'd5,
    FN_MAC = 3'd6,
    FN_SEL = 3'd7
  } func_e;

  logic                  w_en_eff;
  func_e                 w_func;
  logic [DATA_WIDTH-1:0] w_prod;
  logic [DATA_WIDTH-1:0] w_acc_base;
  logic [DATA_WIDTH-1:0] w_res;
  logic                  w_ovf;
  logic                  w_accept;
  logic                  w_hole;
  logic [PIPE_DEPTH-1:0] w_ld;

  logic [DATA_WIDTH-1:0] r_acc;
  logic [PIPE_DEPTH-1:0] r_valid;
  logic [PIPE_DEPTH-1:0] r_ovf;
  logic [DATA_WIDTH-1:0] r_data [PIPE_DEPTH];

  assign w_en_eff = (TIDE_EN != 0) | en;
  assign w_func   = func_e'((DYNAMIC_FUNC != 0) ? alu_func : 3'(ALU_FUNC));

  always_comb begin
    w_prod     = data_in1 * data_in2;
    w_acc_base = acc_clr ? '0 : r_acc;
    w_res      = '0;
    w_ovf      = 1'b0;
    unique case (w_func)
      FN_ADD: begin
        w_res = data_in1 + data_in2;
        w_ovf = (data_in1[MSB] == data_in2[MSB]) && (w_res[MSB] != data_in1[MSB]);
      end
      FN_SUB: begin
        w_res = data_in1 - data_in2;
        w_ovf = (data_in1[MSB] != data_in2[MSB]) && (w_res[MSB] != data_in1[MSB]);
      end
      FN_AND: w_res = data_in1 & data_in2;
      FN_OR:  w_res = data_in1 | data_in2;
      FN_XOR: w_res = data_in1 ^ data_in2;
      FN_MAD: w_res = w_prod + data_in3;
      FN_MAC: begin
        w_res = w_acc_base + w_prod;
        w_ovf = (w_acc_base[MSB] == w_prod[MSB]) && (w_res[MSB] != w_acc_base[MSB]);
      end
      FN_SEL: w_res = data_in3[0] ? data_in1 : data_in2;
      default: w_res = '0;
    endcase
  end

  // Stage k may load when en_eff and some stage at or after k is empty or the
  // sink is taking; accumulated from the output end to avoid a self-referencing chain.
  always_comb begin
    w_hole = out_ready;
    w_ld   = '0;
    for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
      w_hole                  = w_hole | ~r_valid[PIPE_DEPTH-1-k];
      w_ld[PIPE_DEPTH-1-k]    = w_en_eff & w_hole;
    end
  end

  assign in_ready  = ~rst & w_ld[0];
  assign w_accept  = in_valid & in_ready;

  assign data_out  = r_data[PIPE_DEPTH-1];
  assign ovf_out   = r_ovf[PIPE_DEPTH-1];
  assign out_valid = r_valid[PIPE_DEPTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc   <= '0;
      r_valid <= '0;
      r_ovf   <= '0;
      for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
        r_data[k] <= '0;
      end
    end else begin
      if (w_accept && (w_func == FN_MAC)) begin
        r_acc <= w_res;
      end
      if (w_ld[0]) begin
        r_valid[0] <= w_accept;
        r_data[0]  <= w_res;
        r_ovf[0]   <= w_ovf;
      end
      for (int unsigned k = 1; k < PIPE_DEPTH; k++) begin
        if (w_ld[k]) begin
          r_valid[k] <= r_valid[k-1];
          r_data[k]  <= r_data[k-1];
          r_ovf[k]   <= r_ovf[k-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe_unit.sv
// Bench for alu_pipe_unit: vector table plus directed backpressure, enable-freeze
// and reset sequences, checked through an expected-result queue.
module tb_alu_pipe_unit;

  localparam int DW = 32;
  localparam int D  = 2;

  logic          clk = 1'b0;
  logic          rst, en, acc_clr, in_valid, out_ready;
  logic [2:0]    alu_func;
  logic [DW-1:0] data_in1, data_in2, data_in3;
  logic          in_ready, ovf_out, out_valid;
  logic [DW-1:0] data_out;

  logic          u2_in_ready, u2_ovf, u2_out_valid;
  logic [DW-1:0] u2_data;
  logic [2:0]    u2_func = 3'd1;

  alu_pipe_unit #(.DATA_WIDTH(DW), .PIPE_DEPTH(D), .ALU_FUNC(0), .DYNAMIC_FUNC(1), .TIDE_EN(0)) dut (
    .clk(clk), .rst(rst), .en(en), .alu_func(alu_func),
    .data_in1(data_in1), .data_in2(data_in2), .data_in3(data_in3), .acc_clr(acc_clr),
    .in_valid(in_valid), .in_ready(in_ready), .data_out(data_out), .ovf_out(ovf_out),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  // Static-function instance; its alu_func is tied to SUB and must be ignored.
  alu_pipe_unit #(.DATA_WIDTH(DW), .PIPE_DEPTH(D), .ALU_FUNC(0), .DYNAMIC_FUNC(0), .TIDE_EN(0)) u2 (
    .clk(clk), .rst(rst), .en(en), .alu_func(u2_func),
    .data_in1(data_in1), .data_in2(data_in2), .data_in3(data_in3), .acc_clr(acc_clr),
    .in_valid(in_valid), .in_ready(u2_in_ready), .data_out(u2_data), .ovf_out(u2_ovf),
    .out_valid(u2_out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic          o;
  } exp_t;

  typedef struct {
    logic [2:0]    f;
    logic [DW-1:0] a, b, c;
    logic          clr;
    logic [DW-1:0] d;
    logic          o;
  } vec_t;

  exp_t          q[$];
  vec_t          tbl[15];
  int            n_vec = 0, n_miss = 0, n_acc = 0, n_out = 0, cyc = 0;
  logic [DW-1:0] m_acc = '0;
  logic          tb_use_exp = 1'b0;
  logic [DW-1:0] tb_exp_d = '0;
  logic          tb_exp_o = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [2:0] f, input logic [DW-1:0] a, b, c,
                                 input logic clr, inout logic [DW-1:0] acc);
    exp_t          e;
    logic [DW-1:0] p, base;
    p      = a * b;
    base   = clr ? '0 : acc;
    e.o    = 1'b0;
    case (f)
      3'd0: begin e.d = a + b; e.o = (a[DW-1] == b[DW-1]) && (e.d[DW-1] != a[DW-1]); end
      3'd1: begin e.d = a - b; e.o = (a[DW-1] != b[DW-1]) && (e.d[DW-1] != a[DW-1]); end
      3'd2: e.d = a & b;
      3'd3: e.d = a | b;
      3'd4: e.d = a ^ b;
      3'd5: e.d = p + c;
      3'd6: begin
        e.d = base + p;
        e.o = (base[DW-1] == p[DW-1]) && (e.d[DW-1] != base[DW-1]);
        acc = e.d;
      end
      default: e.d = c[0] ? a : b;
    endcase
    return e;
  endfunction

  // Handshake sampled mid-cycle; the coming rising edge acts on these values.
  always @(negedge clk) begin
    int   occ;
    logic emit, m_rdy;
    exp_t e, got;
    if (rst) begin
      chk("in_ready_in_reset", in_ready, 1'b0);
      q.delete();
      m_acc = '0;
    end else begin
      occ   = q.size();
      emit  = out_valid & out_ready & en;
      m_rdy = en & ((occ < D) | out_ready);
      chk("in_ready", in_ready, m_rdy);
      if (emit) begin
        if (occ == 0) begin
          n_vec++; n_miss++;
          $display("FAIL spurious_out: got data 0x%0h, want no output", data_out);
        end else begin
          got = q.pop_front();
          chk("data_out", data_out, got.d);
          chk("ovf_out", ovf_out, got.o);
          n_out++;
        end
      end
      if (in_valid && m_rdy) begin
        e = model(alu_func, data_in1, data_in2, data_in3, acc_clr, m_acc);
        if (tb_use_exp) begin
          e.d = tb_exp_d;
          e.o = tb_exp_o;
        end
        q.push_back(e);
        n_acc++;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_accept(input int base);
    for (int i = 0; i < 50 && n_acc == base; i++) cycles(1);
    if (n_acc == base) begin
      n_vec++; n_miss++;
      $display("FAIL accept_timeout: got %0d accepts, want %0d", n_acc, base + 1);
    end
  endtask

  task automatic send(input logic [2:0] f, input logic [DW-1:0] a, b, c, input logic clr,
                      input logic ue, input logic [DW-1:0] ed, input logic eo);
    int base;
    base       = n_acc;
    alu_func   = f;  data_in1 = a;  data_in2 = b;  data_in3 = c;  acc_clr = clr;
    tb_use_exp = ue; tb_exp_d = ed; tb_exp_o = eo;
    in_valid   = 1'b1;
    wait_accept(base);
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && q.size() != 0; i++) cycles(1);
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    int base, obase, c0;
    tbl[0]  = '{3'd0, 32'h7FFF_FFFF, 32'h1,        32'h0, 1'b0, 32'h8000_0000, 1'b1};
    tbl[1]  = '{3'd2, 32'hF0,        32'h3C,       32'h0, 1'b0, 32'h30,        1'b0};
    tbl[2]  = '{3'd5, 32'd3,         32'd4,        32'd10,1'b0, 32'd22,        1'b0};
    tbl[3]  = '{3'd1, 32'h8000_0000, 32'h1,        32'h0, 1'b0, 32'h7FFF_FFFF, 1'b1};
    tbl[4]  = '{3'd1, 32'd5,         32'd7,        32'h0, 1'b0, 32'hFFFF_FFFE, 1'b0};
    tbl[5]  = '{3'd3, 32'hF0,        32'h0F,       32'h0, 1'b0, 32'hFF,        1'b0};
    tbl[6]  = '{3'd4, 32'hFF,        32'h0F,       32'h0, 1'b0, 32'hF0,        1'b0};
    tbl[7]  = '{3'd7, 32'hAA,        32'h55,       32'h1, 1'b0, 32'hAA,        1'b0};
    tbl[8]  = '{3'd7, 32'hAA,        32'h55,       32'h2, 1'b0, 32'h55,        1'b0};
    tbl[9]  = '{3'd0, 32'hFFFF_FFFF, 32'h1,        32'h0, 1'b0, 32'h0,         1'b0};
    tbl[10] = '{3'd0, 32'h8000_0000, 32'h8000_0000,32'h0, 1'b0, 32'h0,         1'b1};
    tbl[11] = '{3'd5, 32'h1_0000,    32'h1_0000,   32'd5, 1'b0, 32'd5,         1'b0};
    tbl[12] = '{3'd6, 32'd2,         32'd3,        32'h0, 1'b1, 32'd6,         1'b0};
    tbl[13] = '{3'd6, 32'd4,         32'd5,        32'h0, 1'b0, 32'd26,        1'b0};
    tbl[14] = '{3'd6, 32'd1,         32'd1,        32'h0, 1'b1, 32'd1,         1'b0};

    rst = 1'b1; en = 1'b1; out_ready = 1'b1; in_valid = 1'b0; acc_clr = 1'b0;
    alu_func = 3'd0; data_in1 = '0; data_in2 = '0; data_in3 = '0;
    cycles(2);
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_ovf_out", ovf_out, 1'b0);
    chk("rst_u2_out_valid", u2_out_valid, 1'b0);

    // Single add beat: not visible right after accept, visible one edge later.
    send(3'd0, 32'd5, 32'd7, 32'd0, 1'b0, 1'b1, 32'd12, 1'b0);
    in_valid = 1'b0;
    chk("lat_early_valid", out_valid, 1'b0);
    cycles(1);
    chk("lat_out_valid", out_valid, 1'b1);
    chk("lat_data_out", data_out, 32'd12);
    chk("static_out_valid", u2_out_valid, 1'b1);
    chk("static_data_out", u2_data, 32'd12);
    drain();

    // Back-to-back table vectors: one accept per cycle.
    c0 = cyc;
    for (int i = 0; i < 15; i++)
      send(tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].clr, 1'b1, tbl[i].d, tbl[i].o);
    in_valid = 1'b0;
    chk("throughput_cycles", 64'(cyc - c0), 64'd15);
    drain();

    // Backpressure: only D beats fit, output held stable.
    out_ready = 1'b0; base = n_acc; obase = n_out; tb_use_exp = 1'b0;
    for (int i = 0; i < 5; i++) begin
      alu_func = 3'd0; data_in1 = 32'(100 + n_acc - base); data_in2 = '0; in_valid = 1'b1;
      cycles(1);
    end
    chk("bp_accepted", 64'(n_acc - base), 64'd2);
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_hold_valid", out_valid, 1'b1);
    chk("bp_hold_data", data_out, 32'd100);
    in_valid = 1'b0; out_ready = 1'b1;
    drain();
    chk("bp_emitted", 64'(n_out - obase), 64'd2);

    // Enable freeze with one beat at the output and another offered.
    send(3'd6, 32'd2, 32'd3, 32'd0, 1'b1, 1'b1, 32'd6, 1'b0);
    in_valid = 1'b0;
    cycles(1);
    en = 1'b0;
    alu_func = 3'd6; data_in1 = 32'd1; data_in2 = 32'd1; acc_clr = 1'b0;
    tb_use_exp = 1'b1; tb_exp_d = 32'd7; tb_exp_o = 1'b0; in_valid = 1'b1;
    base = n_acc;
    for (int i = 0; i < 3; i++) begin
      cycles(1);
      chk("en0_out_valid", out_valid, 1'b1);
      chk("en0_data_out", data_out, 32'd6);
      chk("en0_in_ready", in_ready, 1'b0);
    end
    chk("en0_no_accept", 64'(n_acc - base), 64'd0);
    en = 1'b1;
    wait_accept(base);
    in_valid = 1'b0;
    drain();

    // Reset with two beats in flight and acc=26; next MAC starts from zero.
    out_ready = 1'b0;
    send(3'd6, 32'd2, 32'd3, 32'd0, 1'b1, 1'b1, 32'd6, 1'b0);
    send(3'd6, 32'd4, 32'd5, 32'd0, 1'b0, 1'b1, 32'd26, 1'b0);
    in_valid = 1'b0;
    cycles(1);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_data_out", data_out, 32'd0);
    out_ready = 1'b1;
    send(3'd6, 32'd1, 32'd1, 32'd0, 1'b0, 1'b1, 32'd1, 1'b0);
    in_valid = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
